// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings, FSM state
// codes and the counter sizing helper used by the unit, controller and hazard decode.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    // Counter holds N-1 at most, so clog2 of the larger latency is enough.
    function automatic int cntWidth(input int multCycles, input int divCycles);
        int maxCycles;
        maxCycles = (multCycles > divCycles) ? multCycles : divCycles;
        return (maxCycles <= 1) ? 1 : $clog2(maxCycles);
    endfunction

    function automatic logic isMulDivOp(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/control bundle between the E stage and the multiply/divide unit.
interface mult_div_unit_if;

    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        start;
    logic        Req;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output A, B, MDOp, start, Req,
        input  Busy, HI, LO
    );

    modport slave (
        input  A, B, MDOp, start, Req,
        output Busy, HI, LO
    );

endinterface

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/DIV as fixed-latency ops
// with the result staged at issue and committed when the busy counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   md
);

    localparam int CntW = cntWidth(MULT_CYCLES, DIV_CYCLES);

    logic [0:0]      stateReg;
    logic [CntW-1:0] countReg;
    logic [31:0]     hiReg;
    logic [31:0]     loReg;
    logic [31:0]     stageHiReg;
    logic [31:0]     stageLoReg;

    logic [63:0]     signedProd;
    logic [63:0]     unsignedProd;
    logic            divByZero;
    logic            divOverflow;
    logic [31:0]     safeDivisor;
    logic [31:0]     signedQuo;
    logic [31:0]     signedRem;
    logic [31:0]     unsignedQuo;
    logic [31:0]     unsignedRem;
    logic [31:0]     resHi;
    logic [31:0]     resLo;
    logic            issueOp;
    logic            isDivIssue;

    assign signedProd   = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    assign unsignedProd = {32'd0, md.A} * {32'd0, md.B};

    // The divisor is forced to 1 for the zero and INT_MIN/-1 cases so the
    // dividers never see an undefined operation; those results are overridden below.
    assign divByZero   = (md.B == 32'd0);
    assign divOverflow = (md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF);
    assign safeDivisor = (divByZero || divOverflow) ? 32'd1 : md.B;

    assign signedQuo   = $signed(md.A) / $signed(safeDivisor);
    assign signedRem   = $signed(md.A) % $signed(safeDivisor);
    assign unsignedQuo = md.A / safeDivisor;
    assign unsignedRem = md.A % safeDivisor;

    always_comb begin
        resHi = hiReg;
        resLo = loReg;
        case (md.MDOp)
            MD_MULT:  {resHi, resLo} = signedProd;
            MD_MULTU: {resHi, resLo} = unsignedProd;
            MD_DIV: begin
                if (divOverflow) begin
                    resHi = 32'd0;
                    resLo = 32'h8000_0000;
                end else if (!divByZero) begin
                    resHi = signedRem;
                    resLo = signedQuo;
                end
            end
            MD_DIVU: begin
                if (!divByZero) begin
                    resHi = unsignedRem;
                    resLo = unsignedQuo;
                end
            end
            default: begin
                resHi = hiReg;
                resLo = loReg;
            end
        endcase
    end

    assign issueOp    = md.start && !md.Req && isMulDivOp(md.MDOp);
    assign isDivIssue = (md.MDOp == MD_DIV) || (md.MDOp == MD_DIVU);

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= ST_IDLE;
            countReg   <= '0;
            hiReg      <= 32'd0;
            loReg      <= 32'd0;
            stageHiReg <= 32'd0;
            stageLoReg <= 32'd0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (issueOp) begin
                        stageHiReg <= resHi;
                        stageLoReg <= resLo;
                        countReg   <= isDivIssue ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
                        stateReg   <= ST_BUSY;
                    end else if (!md.start && !md.Req) begin
                        if (md.MDOp == MD_MTHI) begin
                            hiReg <= md.A;
                        end
                        if (md.MDOp == MD_MTLO) begin
                            loReg <= md.A;
                        end
                    end
                end
                ST_BUSY: begin
                    // Req does not cancel an op already issued; it always commits.
                    if (countReg == '0) begin
                        hiReg    <= stageHiReg;
                        loReg    <= stageLoReg;
                        stateReg <= ST_IDLE;
                    end else begin
                        countReg <= countReg - 1'b1;
                    end
                end
                default: stateReg <= ST_IDLE;
            endcase
        end
    end

    assign md.Busy = (stateReg == ST_BUSY);
    assign md.HI   = hiReg;
    assign md.LO   = loReg;

    // The hazard unit must stall any new mult/div or MTHI/MTLO while busy.
    startWhileBusy: assert property (@(posedge clk) disable iff (reset)
        !(md.Busy && md.start));
    moveWhileBusy: assert property (@(posedge clk) disable iff (reset)
        !(md.Busy && !md.start && !md.Req && ((md.MDOp == MD_MTHI) || (md.MDOp == MD_MTLO))));

endmodule
